// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

  // Operation phases: waiting for operands, shifting bits, holding result.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full adder cell shared with the ripple-carry adder family.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Pure combinational sum and carry-out.
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (a & ci) | (b & ci);
  end

endmodule : full_adder

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b, processed LSB-first, one bit per
// clock, using a single full adder fed with a, ~b and a carry preset to 1.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow
);

  // Bit counter wide enough to index WIDTH-1; it never needs to reach WIDTH.
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_q,     state_d;
  logic [WIDTH-1:0]  a_q,         a_d;
  logic [WIDTH-1:0]  b_q,         b_d;
  logic [WIDTH-1:0]  diff_q,      diff_d;
  logic              carry_q,     carry_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              borrow_q,    borrow_d;

  logic              b_inv;
  logic              fa_s;
  logic              fa_co;

  // Subtraction as addition of the one's complement; the preset carry of 1
  // completes the two's complement of b.
  assign b_inv = ~b_q[0];

  full_adder u_fa (
    .a  (a_q[0]),
    .b  (b_inv),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state, datapath shifting and result capture.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers latches.
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    diff_d      = diff_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    borrow_d    = borrow_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        diff_d  = {fa_s, diff_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == LAST_BIT) begin
          // Final bit: the carry out of the MSB is the inverted borrow.
          cnt_d       = '0;
          borrow_d    = ~fa_co;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        // Result and borrow are frozen here until the consumer takes them.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      // NOTE: the shift registers are ordinary flops, not a memory, and are
      // cleared so d reads zero straight out of reset.
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      diff_q      <= diff_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      borrow_q    <= borrow_d;
    end
  end

  // Only in_ready is decoded combinationally; all other outputs are flops.
  assign in_ready  = (state_q == ST_IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign d         = diff_q;
  assign borrow    = borrow_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 8.
module tb_serial_subtractor;

  localparam int W       = 8;
  localparam int TIMEOUT = 40;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         borrow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .borrow    (borrow)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it; inputs change and outputs are
  // sampled only at this point, away from the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, wait for the result, then take it.
  // Returns the cycles from acceptance to out_valid and the observed result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output int lat, output logic [W-1:0] dv,
                        output logic bo);
    in_valid  = 1'b1;
    a         = av;
    b         = bv;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    dv = d;
    bo = borrow;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (in_ready !== 1'b0)
        $display("FAIL reset_in_ready_during cyc=%0d got=%b exp=0", i, in_ready);
      else pass_cnt++;
    end
    rst = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready_after got=%b exp=1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (d !== 8'd0) $display("FAIL reset_d got=%0d exp=0", d);
    else pass_cnt++;
    total_cnt++;
    if (borrow !== 1'b0) $display("FAIL reset_borrow got=%b exp=0", borrow);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int lat;
    logic [W-1:0] dv;
    logic bo;
    // Check in_ready drops while busy, then run the whole operation.
    in_valid = 1'b1; a = 8'd200; b = 8'd55; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL basic_in_ready_busy got=%b exp=0", in_ready);
    else pass_cnt++;
    lat = 1;
    tick();
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== W) $display("FAIL basic_latency got=%0d exp=%0d", lat, W);
    else pass_cnt++;
    total_cnt++;
    if (d !== 8'd145) $display("FAIL basic_d got=%0d exp=145", d);
    else pass_cnt++;
    total_cnt++;
    if (borrow !== 1'b0) $display("FAIL basic_borrow got=%b exp=0", borrow);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL basic_back_to_idle in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid);
    else pass_cnt++;
    // Repeat through the common driver to confirm identical results.
    run_op(8'd200, 8'd55, lat, dv, bo);
    total_cnt++;
    if (dv !== 8'd145 || bo !== 1'b0 || lat !== W)
      $display("FAIL basic_repeat d=%0d borrow=%b lat=%0d exp=145,0,%0d", dv, bo, lat, W);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    int lat;
    logic [W-1:0] dv;
    logic bo;
    run_op(8'd5, 8'd10, lat, dv, bo);
    total_cnt++;
    if (dv !== 8'd251 || bo !== 1'b1 || lat !== W)
      $display("FAIL underflow_5_10 d=%0d borrow=%b lat=%0d exp=251,1,%0d", dv, bo, lat, W);
    else pass_cnt++;
    run_op(8'd0, 8'd255, lat, dv, bo);
    total_cnt++;
    if (dv !== 8'd1 || bo !== 1'b1 || lat !== W)
      $display("FAIL underflow_0_255 d=%0d borrow=%b lat=%0d exp=1,1,%0d", dv, bo, lat, W);
    else pass_cnt++;
  endtask

  task automatic test_edges();
    int lat;
    logic [W-1:0] dv;
    logic bo;
    run_op(8'hAA, 8'hAA, lat, dv, bo);
    total_cnt++;
    if (dv !== 8'h00 || bo !== 1'b0 || lat !== W)
      $display("FAIL edge_equal d=%0h borrow=%b lat=%0d exp=00,0,%0d", dv, bo, lat, W);
    else pass_cnt++;
    run_op(8'hFF, 8'h00, lat, dv, bo);
    total_cnt++;
    if (dv !== 8'hFF || bo !== 1'b0 || lat !== W)
      $display("FAIL edge_ff_0 d=%0h borrow=%b lat=%0d exp=ff,0,%0d", dv, bo, lat, W);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    // First operands accepted; second pair stays presented throughout.
    in_valid = 1'b1; a = 8'd9; b = 8'd3; out_ready = 1'b0;
    tick();
    a = 8'd4; b = 8'd7;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== W || d !== 8'd6 || borrow !== 1'b0)
      $display("FAIL b2b_first lat=%0d d=%0d borrow=%b exp=%0d,6,0", lat, d, borrow, W);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || d !== 8'd6 || borrow !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL b2b_hold cyc=%0d out_valid=%b d=%0d borrow=%b in_ready=%b exp=1,6,0,0",
                 i, out_valid, d, borrow, in_ready);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL b2b_idle in_ready=%b out_valid=%b exp=1,0", in_ready, out_valid);
    else pass_cnt++;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    total_cnt++;
    if (lat !== W || d !== 8'hFD || borrow !== 1'b1)
      $display("FAIL b2b_second lat=%0d d=%0h borrow=%b exp=%0d,fd,1", lat, d, borrow, W);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    logic [W-1:0] dv;
    logic bo;
    in_valid = 1'b1; a = 8'h55; b = 8'h11; out_ready = 1'b0;
    tick();                                 // E0: accepted
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();     // E1..E4: bits 0..3
    rst = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL midrst_in_ready got=%b exp=0", in_ready);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (out_valid === 1'b1) seen++;
      tick();
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL midrst_no_out_valid got=%0d exp=0", seen);
    else pass_cnt++;
    run_op(8'd100, 8'd1, lat, dv, bo);
    total_cnt++;
    if (dv !== 8'd99 || bo !== 1'b0 || lat !== W)
      $display("FAIL midrst_next_op d=%0d borrow=%b lat=%0d exp=99,0,%0d", dv, bo, lat, W);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_edges();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_serial_subtractor
